pc_stack: RTL and testbench
===========================

# pc_stack

Program counter for the Hack-style CPU, built on the same load/hold register semantics as the `DFF` bit cell (`load=1` captures, `load=0` holds). It sits directly downstream of the bit and word registers and feeds the instruction-memory address. It adds a small hardware return-address stack so `call` (jump and save return) and `ret` (restore) complete in one cycle. All state is registered on the rising edge of `clk`.

## Interface
Parameters:
- `WIDTH`, 16: counter/address width in bits.
- `DEPTH`, 4: return-stack entries. Power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge.
- `in`  in  WIDTH  jump target.
- `load`  in  1  load `in` into `out`.
- `inc`  in  1  increment `out`.
- `push`  in  1  with `load`: call (save `out+1`, then jump).
- `pop`  in  1  return: `out` ← top of stack.
- `out`  out  WIDTH  current PC, registered.
- `depth`  out  $clog2(DEPTH)+1  entries in use, registered.
- `empty`  out  1  `depth==0`, registered.
- `full`  out  1  `depth==DEPTH`, registered.
- `err`  out  1  sticky overflow/underflow flag, registered.

## Operation
Priority is evaluated each rising edge, with the first match winning:
1. **`reset`**: `out`=0, `depth`=0, `empty`=1, `full`=0, `err`=0. Stack contents are don't-care. All other inputs are ignored.
2. **`pop`**:
   - If not empty: `out` ← `stack[depth-1]`, `depth`−1.
   - If empty: `out` holds, `depth` holds, `err` ← 1.
   - `load`/`inc`/`push` are ignored this cycle.
3. **`load`**: `out` ← `in`. If `push` is also asserted:
   - If not full: `stack[depth]` ← `out+1` (mod 2^WIDTH, using pre-edge `out`), `depth`+1.
   - If full: the stack is unchanged, `err` ← 1, and the load still happens.
   - `inc` is ignored.
4. **`inc`**: `out` ← `out+1` mod 2^WIDTH. `0xFFFF` wraps to `0x0000` with no flag.
5. **Otherwise**: everything holds. `push` without `load` is ignored, with no `err`.

Further rules:
- `err` is sticky and is cleared only by `reset`.
- `empty` and `full` are derived from the registered `depth` and update on the same edge as `depth`.
- No combinational path exists from any input to any output.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on outputs after edge N.
- Reset mid-operation (e.g. during a call with a full stack) overrides everything on that edge. The next cycle shows `out`=0, `depth`=0, `err`=0.
- A call at `out=0xFFFF` pushes `0x0000`.
- `pop` and `load`+`push` asserted in the same cycle: the pop wins, there is no net stack change beyond the pop, and `in` is discarded.
- Back-to-back call/ret on consecutive cycles is supported with no bubbles.
- Inputs must be stable around the rising edge. Changes between edges have no effect (level-sampled, as in `DFF`).

## Test plan
- **Reset/inc:** `reset`=1 for one edge, then `inc`=1 for 3 edges → `out`=0,1,2,3; `depth`=0, `empty`=1, `err`=0.
- **Load/hold/wrap:**
  - `load`=1, `in`=0xFFFE, then `inc` for 2 edges → `out`=0xFFFE, 0xFFFF, 0x0000.
  - All controls low for 2 edges → `out` stays 0x0000.
- **Call/ret:**
  - At `out`=0x0010, `load`=`push`=1, `in`=0x0100 → `out`=0x0100, `depth`=1.
  - `inc` ×2 → `out`=0x0102.
  - `pop` → `out`=0x0011, `depth`=0, `empty`=1.
- **Overflow:**
  - 4 calls from `out`=0 (each `in`=0x0200+k) → `depth`=4, `full`=1.
  - A 5th call with `in`=0x0300 → `out`=0x0300, `depth`=4, `err`=1.
  - 4 pops return 0x0204, 0x0203, 0x0202, 0x0001 in that order.
- **Underflow/priority:**
  - With the stack empty, `pop`=`load`=`inc`=1, `in`=0x1234 → `out` unchanged, `err`=1.
  - `push` alone with `out`=5 → `out`=5, `depth`=0, no further change.
- **Reset mid-operation:** with `depth`=3 and `err`=1, assert `reset` together with `load`+`push` → after the edge `out`=0, `depth`=0, `empty`=1, `full`=0, `err`=0.

Source files
------------

// File: rtl/pc_stack.sv
// Hack-style program counter with a small hardware return-address stack.
// call (load+push) saves out+1 and jumps in one cycle; pop restores it.
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       push,
  input  logic                       pop,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] ret_addr;
  logic [DW-1:0]    depth_nxt;
  logic [AW-1:0]    top_idx;
  logic             err_nxt;
  logic             do_push;

  assign ret_addr = out + WIDTH'(1);
  assign top_idx  = depth[AW-1:0] - AW'(1);

  // Priority: pop, then load (with optional push), then inc, else hold.
  always_comb begin
    out_nxt   = out;
    depth_nxt = depth;
    err_nxt   = err;
    do_push   = 1'b0;
    if (pop) begin
      if (empty) begin
        err_nxt = 1'b1;
      end else begin
        out_nxt   = stack[top_idx];
        depth_nxt = depth - DW'(1);
      end
    end else if (load) begin
      out_nxt = in;
      if (push) begin
        if (full) begin
          err_nxt = 1'b1;
        end else begin
          do_push   = 1'b1;
          depth_nxt = depth + DW'(1);
        end
      end
    end else if (inc) begin
      out_nxt = ret_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out   <= '0;
      depth <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      err   <= 1'b0;
    end else begin
      out   <= out_nxt;
      depth <= depth_nxt;
      empty <= (depth_nxt == '0);
      full  <= (depth_nxt == DW'(DEPTH));
      err   <= err_nxt;
    end
  end

  // Stack contents need no reset; depth alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      stack[depth[AW-1:0]] <= ret_addr;
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Directed table-driven bench for pc_stack plus a few multi-cycle sequences.
module tb_pc_stack;

  logic        clk = 1'b0;
  logic        reset, load, inc, push, pop;
  logic [15:0] in;
  logic [15:0] out;
  logic [2:0]  depth;
  logic        empty, full, err;

  int checks = 0;
  int failures = 0;

  pc_stack #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc),
    .push(push), .pop(pop), .out(out), .depth(depth),
    .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] din;
    logic        ld, ic, ps, pp;
    logic [15:0] eo;
    logic [2:0]  ed;
    logic        ee, ef, er;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [15:0] din,
                     input logic ld, input logic ic, input logic ps, input logic pp,
                     input logic [15:0] eo, input logic [2:0] ed,
                     input logic ee, input logic ef, input logic er);
    vec_t v;
    v.rst = rst; v.din = din; v.ld = ld; v.ic = ic; v.ps = ps; v.pp = pp;
    v.eo = eo; v.ed = ed; v.ee = ee; v.ef = ef; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    reset = v.rst; in = v.din; load = v.ld; inc = v.ic; push = v.ps; pop = v.pp;
    @(posedge clk);
    #1;
    cmp({tag, ".out"},   out,          v.eo);
    cmp({tag, ".depth"}, 16'(depth),   16'(v.ed));
    cmp({tag, ".empty"}, 16'(empty),   16'(v.ee));
    cmp({tag, ".full"},  16'(full),    16'(v.ef));
    cmp({tag, ".err"},   16'(err),     16'(v.er));
  endtask

  task automatic run_queue(input string tag);
    for (int i = 0; i < vecs.size(); i++) step($sformatf("%s[%0d]", tag, i), vecs[i]);
    vecs.delete();
  endtask

  initial begin
    reset = 1'b0; in = '0; load = 0; inc = 0; push = 0; pop = 0;
    @(negedge clk);

    //  rst  in       ld ic ps pp  out      d  e  f  err
    add(1, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 0, 16'h0001, 0, 1, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 0, 16'h0002, 0, 1, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 0, 16'h0003, 0, 1, 0, 0);
    add(0, 16'hFFFE, 1, 0, 0, 0, 16'hFFFE, 0, 1, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 0, 16'hFFFF, 0, 1, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 16'h0010, 1, 0, 0, 0, 16'h0010, 0, 1, 0, 0);
    add(0, 16'h0100, 1, 0, 1, 0, 16'h0100, 1, 0, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 0, 16'h0101, 1, 0, 0, 0);
    add(0, 16'h0000, 0, 1, 0, 0, 16'h0102, 1, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 1, 16'h0011, 0, 1, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 16'h0201, 1, 0, 1, 0, 16'h0201, 1, 0, 0, 0);
    add(0, 16'h0202, 1, 0, 1, 0, 16'h0202, 2, 0, 0, 0);
    add(0, 16'h0203, 1, 0, 1, 0, 16'h0203, 3, 0, 0, 0);
    add(0, 16'h0204, 1, 1, 1, 0, 16'h0204, 4, 0, 1, 0);
    add(0, 16'h0300, 1, 0, 1, 0, 16'h0300, 4, 0, 1, 1);
    add(0, 16'h0000, 0, 0, 0, 1, 16'h0204, 3, 0, 0, 1);
    add(0, 16'h0000, 0, 0, 0, 1, 16'h0203, 2, 0, 0, 1);
    add(0, 16'h0000, 0, 0, 0, 1, 16'h0202, 1, 0, 0, 1);
    add(0, 16'h0000, 0, 0, 0, 1, 16'h0001, 0, 1, 0, 1);
    add(1, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 16'h1234, 1, 1, 0, 1, 16'h0000, 0, 1, 0, 1);
    add(0, 16'h0005, 1, 0, 0, 0, 16'h0005, 0, 1, 0, 1);
    add(0, 16'h0000, 0, 0, 1, 0, 16'h0005, 0, 1, 0, 1);
    add(0, 16'h0000, 0, 0, 0, 0, 16'h0005, 0, 1, 0, 1);
    run_queue("tbl");

    // Call at 0xFFFF pushes 0x0000; pop beats load+push; push alone sets no err.
    add(1, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 16'hFFFF, 1, 0, 0, 0, 16'hFFFF, 0, 1, 0, 0);
    add(0, 16'h0040, 1, 0, 1, 0, 16'h0040, 1, 0, 0, 0);
    add(0, 16'h0077, 1, 0, 1, 1, 16'h0000, 0, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 1, 0, 0);
    run_queue("wrapcall");

    // Back-to-back call/ret/call/ret with no idle cycles.
    add(0, 16'h0500, 1, 0, 1, 0, 16'h0500, 1, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 1, 16'h0001, 0, 1, 0, 0);
    add(0, 16'h0600, 1, 0, 1, 0, 16'h0600, 1, 0, 0, 0);
    add(0, 16'h0700, 1, 0, 1, 0, 16'h0700, 2, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 1, 16'h0601, 1, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 1, 16'h0002, 0, 1, 0, 0);
    run_queue("b2b");

    // Reset mid-call with depth=3 and err=1 set.
    add(1, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 1, 0, 1);
    add(0, 16'h0010, 1, 0, 1, 0, 16'h0010, 1, 0, 0, 1);
    add(0, 16'h0020, 1, 0, 1, 0, 16'h0020, 2, 0, 0, 1);
    add(0, 16'h0030, 1, 0, 1, 0, 16'h0030, 3, 0, 0, 1);
    add(1, 16'h0040, 1, 0, 1, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 1, 0, 1);
    run_queue("rstmid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
